// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data-memory responder for the DM pipeline stage.
//               Accepts one read or write, holds it for LAT cycles, then
//               returns read data / error status and raises Done_DM.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int LAT    = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [15:0]       Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done_DM,
    output logic              Err,
    output logic              Busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Reload value for the wait counter; the acceptance cycle is the first
    // of the LAT stall cycles, so WAIT covers the remaining LAT-1.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        count;

    // Request captured at acceptance, used when entering RESP from WAIT
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_idx;
    logic [DATA_W-1:0] req_data;
    logic              err_pend;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Live request decode
    logic              req_live;
    logic              in_err;
    logic [ADDR_W-1:0] in_idx;

    // Access performed on the edge that enters RESP
    logic              enter_resp;
    logic              acc_rd;
    logic              acc_wr;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;
    logic [DATA_W-1:0] acc_data;

    // Upper address bits only alias; they never select anything
    logic              addr_hi_unused;
    assign addr_hi_unused = ^Addr[15:ADDR_W+1];

    assign req_live = Rd | Wr;
    assign in_err   = (Rd & Wr) | Addr[0];
    assign in_idx   = Addr[ADDR_W:1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; errors and LAT=1 skip WAIT entirely
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_live) begin
                    if (in_err || (LAT == 1)) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (count <= 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic; reset forces the idle indication regardless of inputs
    always_comb begin
        Done_DM = 1'b1;
        Busy    = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    Done_DM = ~req_live;
                    Busy    = req_live;
                end
                S_WAIT: begin
                    Done_DM = 1'b0;
                    Busy    = 1'b1;
                end
                default: begin
                    Done_DM = 1'b1;
                    Busy    = 1'b0;
                end
            endcase
        end
    end

    // Select the access source: straight from the inputs when RESP is
    // entered directly from IDLE, otherwise from the captured request
    always_comb begin
        enter_resp = (state != S_RESP) && (state_nxt == S_RESP);
        if (state == S_IDLE) begin
            acc_rd   = Rd;
            acc_wr   = Wr;
            acc_err  = in_err;
            acc_idx  = in_idx;
            acc_data = DataIn;
        end else begin
            acc_rd   = req_rd;
            acc_wr   = req_wr;
            acc_err  = err_pend;
            acc_idx  = req_idx;
            acc_data = req_data;
        end
    end

    // Request capture and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 4'd0;
            req_rd   <= 1'b0;
            req_wr   <= 1'b0;
            req_idx  <= '0;
            req_data <= '0;
            err_pend <= 1'b0;
        end else begin
            if ((state == S_IDLE) && req_live) begin
                req_rd   <= Rd;
                req_wr   <= Wr;
                req_idx  <= in_idx;
                req_data <= DataIn;
                err_pend <= in_err;
                count    <= (in_err || (LAT == 1)) ? 4'd0 : LAT_M1;
            end else if ((state == S_WAIT) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
        end
    end

    // Response registers update only on entry to RESP; they hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DataOut <= '0;
            Err     <= 1'b0;
        end else if (enter_resp) begin
            Err <= acc_err;
            if (!acc_err && acc_rd) begin
                DataOut <= mem[acc_idx];
            end
        end
    end

    // Array write on entry to RESP; suppressed while reset is asserted so a
    // request interrupted by reset never lands in memory
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && !acc_err && acc_wr) begin
            mem[acc_idx] <= acc_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder (LAT=4 and LAT=1
//               instances) against a transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        rd0, wr0, done0, err0, busy0;
    logic [15:0] addr0, din0, dout0;
    logic        rd1, wr1, done1, err1, busy1;
    logic [15:0] addr1, din1, dout1;

    int errors;
    int checks;

    // Reference model: per-instance word store plus expected response regs
    logic [15:0] mm0 [int];
    logic [15:0] mm1 [int];
    logic [15:0] exp_dout [2];
    logic        exp_err  [2];

    dmem_responder #(.LAT(4), .ADDR_W(8), .DATA_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .Rd(rd0), .Wr(wr0), .Addr(addr0),
        .DataIn(din0), .DataOut(dout0), .Done_DM(done0), .Err(err0), .Busy(busy0)
    );

    dmem_responder #(.LAT(1), .ADDR_W(8), .DATA_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .Rd(rd1), .Wr(wr1), .Addr(addr1),
        .DataIn(din1), .DataOut(dout1), .Done_DM(done1), .Err(err1), .Busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request to instance `which` (0: LAT=4, 1: LAT=1) starting
    // in an IDLE cycle, check the stall window and the response cycle.
    task automatic run_req(input int which, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] din,
                           input string name);
        logic        err;
        int          lat;
        int          idx;
        logic        o_done, o_busy, o_err;
        logic [15:0] o_dout;
        err = (rd && wr) || addr[0];
        lat = err ? 1 : ((which == 0) ? 4 : 1);
        idx = (int'(addr) / 2) % 256;
        if (!err) begin
            if (wr) begin
                if (which == 0) mm0[idx] = din; else mm1[idx] = din;
            end
            if (rd) begin
                if (which == 0) exp_dout[0] = mm0[idx];
                else            exp_dout[1] = mm1[idx];
            end
        end
        exp_err[which] = err;
        if (which == 0) begin
            rd0 = rd; wr0 = wr; addr0 = addr; din0 = din;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = addr; din1 = din;
        end
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            o_done = (which == 0) ? done0 : done1;
            o_busy = (which == 0) ? busy0 : busy1;
            o_dout = (which == 0) ? dout0 : dout1;
            o_err  = (which == 0) ? err0  : err1;
            checks++;
            if (o_done !== (c == lat)) begin
                errors++;
                $display("FAIL %s done cyc%0d: got %b want %b", name, c, o_done, (c == lat));
            end
            checks++;
            if (o_busy !== (c < lat)) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b want %b", name, c, o_busy, (c < lat));
            end
            if (c == lat) begin
                checks++;
                if (o_dout !== exp_dout[which]) begin
                    errors++;
                    $display("FAIL %s dataout: got %h want %h", name, o_dout, exp_dout[which]);
                end
                checks++;
                if (o_err !== exp_err[which]) begin
                    errors++;
                    $display("FAIL %s err: got %b want %b", name, o_err, exp_err[which]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (which == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
        else            begin rd1 = 1'b0; wr1 = 1'b0; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_dout[0] = 16'h0000; exp_dout[1] = 16'h0000;
        exp_err[0]  = 1'b0;     exp_err[1]  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({done0, busy0, err0, dout0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_idle4 cyc%0d: done=%b busy=%b err=%b dout=%h want 1 0 0 0000",
                         i, done0, busy0, err0, dout0);
            end
            checks++;
            if ({done1, busy1, err1, dout1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_idle1 cyc%0d: done=%b busy=%b err=%b dout=%h want 1 0 0 0000",
                         i, done1, busy1, err1, dout1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        run_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, "wr_0010");
        run_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, "rd_0010");
    endtask

    task automatic test_back_to_back();
        run_req(0, 1'b0, 1'b1, 16'h0030, 16'h1111, "b2b_wr1");
        run_req(0, 1'b0, 1'b1, 16'h0030, 16'h2222, "b2b_wr2");
        run_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, "b2b_rd");
        run_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, "b2b_rd2");
    endtask

    task automatic test_errors();
        run_req(0, 1'b0, 1'b1, 16'h0020, 16'h7777, "err_prewr");
        run_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, "err_prerd");
        run_req(0, 1'b1, 1'b1, 16'h0010, 16'hFFFF, "err_rdwr");
        run_req(0, 1'b0, 1'b1, 16'h0021, 16'h1234, "err_odd");
        run_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, "err_rdback");
    endtask

    task automatic test_reset_mid_op();
        run_req(0, 1'b0, 1'b1, 16'h0004, 16'h0000, "mid_pre0");
        rd0 = 1'b0; wr0 = 1'b1; addr0 = 16'h0004; din0 = 16'h5555;
        repeat (3) @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_done: got %b want 0", done0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({done0, busy0, err0, dout0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL mid_reset: done=%b busy=%b err=%b dout=%h want 1 0 0 0000",
                     done0, busy0, err0, dout0);
        end
        @(posedge clk);
        #1;
        wr0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_dout[0] = 16'h0000; exp_dout[1] = 16'h0000;
        exp_err[0]  = 1'b0;     exp_err[1]  = 1'b0;
        @(posedge clk);
        #1;
        run_req(0, 1'b1, 1'b0, 16'h0004, 16'h0000, "mid_rdback");
    endtask

    task automatic test_lat1_alias();
        run_req(1, 1'b0, 1'b1, 16'h0202, 16'hA5A5, "l1_wr0202");
        run_req(1, 1'b1, 1'b0, 16'h0002, 16'h0000, "l1_rd0002");
        run_req(1, 1'b1, 1'b1, 16'h0002, 16'h0000, "l1_err");
        run_req(0, 1'b0, 1'b1, 16'h0202, 16'hA5A5, "l4_wr0202");
        run_req(0, 1'b1, 1'b0, 16'h0002, 16'h0000, "l4_rd0002");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          which;
            int          op;
            int          idx;
            logic [15:0] a;
            logic [15:0] d;
            logic        known;
            which = (i % 4 == 3) ? 1 : 0;
            op    = int'($urandom_range(0, 9));
            a     = 16'($urandom_range(0, 15) * 2) | 16'($urandom_range(0, 3) << 9);
            d     = 16'($urandom);
            idx   = (int'(a) / 2) % 256;
            known = (which == 0) ? mm0.exists(idx) : mm1.exists(idx);
            if (op < 4 || (op < 8 && !known))
                run_req(which, 1'b0, 1'b1, a, d, "rnd_wr");
            else if (op < 8)
                run_req(which, 1'b1, 1'b0, a, d, "rnd_rd");
            else if (op == 8)
                run_req(which, 1'b1, 1'b1, a, d, "rnd_rdwr");
            else
                run_req(which, 1'b0, 1'b1, a | 16'h0001, d, "rnd_odd");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 16'h0000; din0 = 16'h0000;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0000; din1 = 16'h0000;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_reset_mid_op();
        test_lat1_alias();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
